// File: rtl/stopwatch_ctrl.sv
// Debounced start/stop and clear keys drive an IDLE/RUN/PAUSE FSM and a clock divider
// that emits a one-cycle TICK count enable while running, plus a one-cycle CLR pulse.
module stopwatch_ctrl #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY_SS,
  input  logic KEY_CLR,
  output logic TICK,
  output logic CLR,
  output logic RUN
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

  // Key index 0 is start/stop, index 1 is clear.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    stable_q, stable_d;
  logic [1:0]    prev_q;
  logic [1:0]    arm_q, arm_d;
  logic [1:0]    press_q, press_d;
  logic [1:0]    vld_q;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  // A key is armed only once it has been seen released after reset, so a key held
  // through reset cannot produce a press until it is let go and pressed again.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      stable_d[k] = stable_q[k];
      cnt_d[k]    = '0;
      if (sync2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == DB_LAST) begin
          stable_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
      arm_d[k]   = arm_q[k] | (vld_q[1] & sync2_q[k]);
      press_d[k] = prev_q[k] & ~stable_q[k] & arm_q[k];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      stable_q <= 2'b11;
      prev_q   <= 2'b11;
      arm_q    <= 2'b00;
      press_q  <= 2'b00;
      vld_q    <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= {KEY_CLR, KEY_SS};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      arm_q    <= arm_d;
      press_q  <= press_d;
      vld_q    <= {vld_q[0], 1'b1};
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  logic ss_ev, clr_ev;
  assign ss_ev  = press_q[0];
  assign clr_ev = press_q[1];

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  logic          clr_q, clr_d;
  logic          run_q, run_d;

  // Clear overrides everything, including a tick due on the same cycle.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    clr_d   = 1'b0;
    if (clr_ev) begin
      state_d = ST_IDLE;
      div_d   = '0;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          div_d = '0;
          if (ss_ev) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            tick_d = 1'b1;
          end else begin
            div_d = div_q + DW'(1);
          end
          if (ss_ev) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (ss_ev) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    run_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      run_q   <= run_d;
    end
  end

  assign TICK = tick_q;
  assign CLR  = clr_q;
  assign RUN  = run_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10, DB_CYCLES=4; key-to-state latency is 7 edges.
module tb_stopwatch_ctrl;
  logic CLK, RST, KEY_SS, KEY_CLR;
  logic TICK, CLR, RUN;

  int n_chk = 0, n_pass = 0;
  int tick_cnt = 0, overlap = 0, t0;
  logic tick_prev = 1'b0, clr_prev = 1'b0;

  stopwatch_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DB_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .KEY_SS(KEY_SS), .KEY_CLR(KEY_CLR),
    .TICK(TICK), .CLR(CLR), .RUN(RUN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (TICK === 1'b1) tick_cnt++;
      if ((TICK === 1'b1 && CLR === 1'b1) || (TICK === 1'b1 && tick_prev) ||
          (CLR === 1'b1 && clr_prev)) overlap++;
      tick_prev = (TICK === 1'b1);
      clr_prev  = (CLR === 1'b1);
    end else begin
      tick_prev = 1'b0;
      clr_prev  = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Each step crosses exactly one rising edge and lands just after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; KEY_SS = 1'b1; KEY_CLR = 1'b1;
    @(negedge CLK); RST = 1'b0; #1;
    chk("rst_run", RUN, 0);
    chk("rst_tick", TICK, 0);
    chk("rst_clr", CLR, 0);
    step(2); RST = 1'b1; step(5);

    // Glitch of 3 samples is ignored.
    KEY_SS = 1'b0; step(3); KEY_SS = 1'b1; step(20);
    chk("glitch_run", RUN, 0);

    // Held press: RUN rises 7 edges after the first low sample (edge T).
    KEY_SS = 1'b0; step(7);
    chk("lat_pre", RUN, 0);
    step(1); chk("lat_run", RUN, 1);
    step(9); chk("tick_t9", TICK, 0);
    step(1); chk("tick_t10", TICK, 1);
    step(1); chk("tick_width", TICK, 0);
    step(9); chk("tick_t20", TICK, 1);
    step(10); chk("tick_t30", TICK, 1);
    step(1); chk("tick_t31", TICK, 0);
    step(61); KEY_SS = 1'b1; step(30);
    chk("release_run", RUN, 1);

    // Now at T+122; clear lands on edge T+130, which is also terminal count.
    t0 = tick_cnt; KEY_CLR = 1'b0; step(7);
    chk("clr_pre", CLR, 0);
    step(1); chk("clr_pulse", CLR, 1);
    chk("clr_run", RUN, 0);
    chk("clr_tc_tick", TICK, 0);
    step(1); chk("clr_width", CLR, 0);
    KEY_CLR = 1'b1;
    chk("clr_tc_cnt", tick_cnt - t0, 0);
    t0 = tick_cnt; step(30);
    chk("idle_no_tick", tick_cnt - t0, 0);

    // Restart after clear (edge T2): full interval.
    KEY_SS = 1'b0; step(8); chk("start2_run", RUN, 1);
    KEY_SS = 1'b1; step(9); chk("start2_t9", TICK, 0);
    step(1); chk("start2_t10", TICK, 1);

    // Pause at T2+26 leaves 6 cycles in the divider.
    step(8); KEY_SS = 1'b0; step(7);
    chk("pause_pre", RUN, 1);
    step(1); chk("pause_run", RUN, 0);
    KEY_SS = 1'b1; t0 = tick_cnt; step(40);
    chk("pause_no_tick", tick_cnt - t0, 0);

    // Resume at R: tick after 4 more RUN cycles, then every 10.
    KEY_SS = 1'b0; step(7); chk("resume_pre", RUN, 0);
    step(1); chk("resume_run", RUN, 1);
    KEY_SS = 1'b1; step(3); chk("resume_r3", TICK, 0);
    step(1); chk("resume_r4", TICK, 1);
    step(10); chk("resume_r14", TICK, 1);

    // Pause again, then both keys together: clear wins.
    KEY_SS = 1'b0; step(8); chk("pause2_run", RUN, 0);
    KEY_SS = 1'b1; step(10);
    KEY_SS = 1'b0; KEY_CLR = 1'b0; step(7);
    chk("both_pre", CLR, 0);
    step(1); chk("both_clr", CLR, 1);
    chk("both_run", RUN, 0);
    step(1); chk("both_width", CLR, 0);
    KEY_SS = 1'b1; KEY_CLR = 1'b1; step(20);
    chk("both_idle_run", RUN, 0);

    // Divider must have been zeroed: fresh start ticks after a full 10 (edge T3).
    KEY_SS = 1'b0; step(8); chk("start3_run", RUN, 1);
    KEY_SS = 1'b1; t0 = tick_cnt; step(9);
    chk("start3_quiet", tick_cnt - t0, 0);
    step(1); chk("start3_t10", TICK, 1);

    // Clear event timed to the terminal count at T3+20 suppresses that tick.
    step(2); t0 = tick_cnt; KEY_CLR = 1'b0; step(8);
    chk("tc_clr", CLR, 1);
    chk("tc_clr_tick", TICK, 0);
    KEY_CLR = 1'b1; step(5);
    chk("tc_clr_cnt", tick_cnt - t0, 0);

    // Pause event at terminal count (T4+20): tick still fires, then PAUSE.
    KEY_SS = 1'b0; step(8); chk("start4_run", RUN, 1);
    KEY_SS = 1'b1; step(12); KEY_SS = 1'b0; step(8);
    chk("ss_tc_tick", TICK, 1);
    chk("ss_tc_run", RUN, 0);
    KEY_SS = 1'b1; t0 = tick_cnt; step(30);
    chk("ss_tc_hold", tick_cnt - t0, 0);

    // Resume, run 5 cycles, then async reset mid-cycle.
    KEY_SS = 1'b0; step(8); chk("resume2_run", RUN, 1);
    KEY_SS = 1'b1; step(5);
    RST = 1'b0; #1;
    chk("arst_run", RUN, 0);
    chk("arst_tick", TICK, 0);
    chk("arst_clr", CLR, 0);
    step(1); RST = 1'b1; t0 = tick_cnt; step(50);
    chk("post_rst_ticks", tick_cnt - t0, 0);
    chk("post_rst_run", RUN, 0);

    // Key held through reset is not a press until released and pressed again.
    KEY_SS = 1'b0; RST = 1'b0; step(2); RST = 1'b1; step(30);
    chk("held_rst_run", RUN, 0);
    KEY_SS = 1'b1; step(10);
    KEY_SS = 1'b0; step(8);
    chk("repress_run", RUN, 1);
    KEY_SS = 1'b1; step(5);

    chk("no_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-end control stage for the seconds-counter/7-segment display path. It debounces two active-low push buttons (start/stop, clear) and runs a RUN/PAUSE/IDLE state machine. It also divides the board clock into a one-cycle `TICK` enable that the downstream seconds counter consumes as its count enable, along with `CLR` as its synchronous clear. The downstream counter holds no free-running prescaler of its own when driven by this block.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency.
- `TICK_HZ`, 1, tick rate; divisor `DIV = CLK_HZ/TICK_HZ` (integer, ≥2), counter width `$clog2(DIV)`.
- `DB_CYCLES`, 1_000_000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz).

Ports:
- `CLK` in 1: single clock, all logic rising-edge.
- `RST` in 1: asynchronous, active-low reset.
- `KEY_SS` in 1: start/stop button, active-low, asynchronous to `CLK`.
- `KEY_CLR` in 1: clear button, active-low, asynchronous to `CLK`.
- `TICK` out 1: registered one-cycle pulse, once per `DIV` RUN cycles.
- `CLR` out 1: registered one-cycle pulse on accepted clear.
- `RUN` out 1: registered level, 1 while in RUN state.

## Operation
- Reset (`RST`=0, immediate): state IDLE; `TICK`=`CLR`=`RUN`=0; divider=0; synchronizer flops and debounced levels=1 (released); debounce counters=0.
- Each key uses a 2-flop synchronizer feeding a debouncer.
  - The debouncer counter clears whenever the synced level equals the stable level.
  - Otherwise the counter increments.
  - When it reaches `DB_CYCLES-1`, the stable level takes the synced value and the counter clears.
- Press event: a one-cycle internal pulse on a stable 1→0 transition. Releases (0→1) generate nothing. A held key yields exactly one event.
- FSM (`ss`/`clr` denote press events):
  - IDLE: divider held at 0. On `ss`, go to RUN.
  - RUN: divider counts 0..DIV-1 and wraps. On `ss`, go to PAUSE.
  - PAUSE: divider holds its value. On `ss`, go to RUN.
  - Any state: on `clr`, go to IDLE; divider←0; `CLR`=1 for the next cycle.
- Priority: `clr` beats `ss` in the same cycle. The `ss` event is discarded and the state goes to IDLE.
- Divider: in RUN, when divider==DIV-1, `TICK`=1 the next cycle and the divider wraps to 0.
- Interrupted interval: pausing preserves the partial count, so ticks occur after exactly `DIV` cumulative RUN cycles.
- Tick suppression:
  - A `clr` event in the terminal-count cycle suppresses that tick.
  - An `ss` (pause) event in the terminal-count cycle does not suppress it: the tick fires, the divider wraps to 0, and the state enters PAUSE.

## Timing
- Key-to-state latency: with a key first sampled low at edge 0 and held, the press event occurs at edge 2+DB_CYCLES. `RUN`/`CLR` change at edge 3+DB_CYCLES.
- Key glitches shorter than `DB_CYCLES` sampled cycles are ignored.
- Entering RUN from IDLE at edge T (divider=0): the first `TICK` is high during cycle T+DIV, then every `DIV` cycles.
- `TICK` and `CLR` are never high for two consecutive cycles and are never high simultaneously.
- Reset asserted mid-operation forces all outputs low asynchronously. After release, the block waits in IDLE; a key held through reset is not treated as a press until it is released and pressed again.

## Test plan
Bench parameters: `CLK_HZ`=10, `TICK_HZ`=1 (DIV=10), `DB_CYCLES`=4.
1. Reset: from RUN with divider=5, pulse `RST` low mid-cycle → `RUN`/`TICK`/`CLR`=0 immediately. After release, no `TICK` for 50 cycles.
2. Debounce: `KEY_SS` low 3 cycles then high → `RUN` stays 0. Hold low 100 cycles → `RUN`=1 exactly 7 edges after first low sample. Exactly one state change; release causes none.
3. Tick rate: after `RUN` rises at edge T → `TICK` pulses at T+10, T+20, T+30, each one cycle wide.
4. Pause/resume: pause after 6 RUN cycles → `RUN`=0, no `TICK` for 40 cycles. Resume → `TICK` after 4 further RUN cycles (10 cumulative).
5. Clear: `KEY_CLR` press during RUN → `CLR` one cycle, `RUN`=0. Next start → first `TICK` 10 cycles after `RUN` rises.
6. Simultaneous: both keys pressed on the same edge while in PAUSE → `CLR`=1 once, `RUN` stays 0, state IDLE. A clear event coincident with terminal count → no `TICK`.
